// File: rtl/fft_pkg.sv
// Shared FFT definitions: fill-mode constants, complex sample layout and a
// constant-evaluable clog2 used to size pointers and counters.
package fft_pkg;

    localparam int FILL_SUPPRESS = 0;
    localparam int FILL_ZERO     = 1;

    // Default-width complex sample; real part occupies the MSBs.
    localparam int CPLX_W = 16;
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_delay_buffer_ram.sv
// Simple-dual-port RAM with a shared address, read-first behaviour and a
// registered read port; no reset so it maps onto block or distributed RAM.
module sdp_ram_rf #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sdf_delay_buffer.sv
// Valid-qualified complex delay line for SDF FFT feedback paths: a circular
// buffer in one RAM that only advances on accepted samples.
module sdf_delay_buffer
    import fft_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 16,
    parameter int FILL_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im
);

    localparam int ADDR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W  = clog2(DEPTH + 1);

    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
        $fatal(1, "sdf_delay_buffer: DEPTH and WIDTH must both be at least 1");
    end

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } sample_t;

    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic                    vld_p0_q, vld_p0_d;
    logic                    zero_p0_q, zero_p0_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_re_q, out_re_d;
    logic signed [WIDTH-1:0] out_im_q, out_im_d;

    logic    accept;
    logic    filled;
    sample_t wr_s;
    sample_t rd_s;

    assign accept = in_valid & ~clr;
    assign filled = (fill_cnt_q == CNT_W'(DEPTH));
    assign wr_s   = '{re: in_re, im: in_im};

    sdp_ram_rf #(
        .ADDR_W(ADDR_W),
        .DATA_W(2 * WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (accept),
        .addr (wr_ptr_q),
        .wdata(wr_s),
        .rdata(rd_s)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        vld_p0_d    = 1'b0;
        zero_p0_d   = zero_p0_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;

        if (clr) begin
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            zero_p0_d  = 1'b0;
            out_re_d   = '0;
            out_im_d   = '0;
        end else begin
            // Stage p0: RAM read issued on the accept edge
            if (in_valid) begin
                wr_ptr_d  = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
                vld_p0_d  = (FILL_MODE == FILL_ZERO) || filled;
                zero_p0_d = ~filled;
                if (!filled) fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
            // Stage p1: output registers load from the RAM read port
            out_valid_d = vld_p0_q;
            if (vld_p0_q) begin
                out_re_d = zero_p0_q ? '0 : rd_s.re;
                out_im_d = zero_p0_q ? '0 : rd_s.im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            vld_p0_q    <= 1'b0;
            zero_p0_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            vld_p0_q    <= vld_p0_d;
            zero_p0_q   <= zero_p0_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_sdf_delay_buffer.sv
// Directed bench for sdf_delay_buffer: six instances (different depths and
// fill modes) share one stimulus bus; each test resets all and checks one or two.
module tb_sdf_delay_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;

    logic               ov  [6];
    logic signed [15:0] ore [6];
    logic signed [15:0] oim [6];

    int checks = 0;
    int errors = 0;

    function automatic int dep_of(input int g);
        case (g)
            0: return 4;
            1: return 4;
            2: return 3;
            3: return 5;
            4: return 1;
            default: return 4096;
        endcase
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_dut
        sdf_delay_buffer #(
            .DEPTH    (dep_of(g)),
            .WIDTH    (16),
            .FILL_MODE((g == 1) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .in_valid (in_valid),
            .in_re    (in_re),
            .in_im    (in_im),
            .out_valid(ov[g]),
            .out_re   (ore[g]),
            .out_im   (oim[g])
        );
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int re);
        in_valid = v;
        in_re    = 16'(re);
        in_im    = 16'(-re);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        drive(1'b0, 0);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    function automatic logic signed [15:0] sre(input int j);
        case (j % 5)
            0:       return -16'sd32768;
            1:       return 16'sd32767;
            default: return 16'(j * 13);
        endcase
    endfunction

    initial begin
        int e_v, e_re, j, m, n;
        int nlong;

        // DEPTH=4 streams, suppress (dut0) and zero-prime (dut1)
        do_reset();
        check("rst_vld", ov[0], 0);
        check("rst_re", ore[0], 0);
        check("rst_im", oim[0], 0);
        check("rst_vld_m1", ov[1], 0);
        for (int k = 0; k < 14; k++) begin
            drive(k < 12, k + 1);
            step();
            e_v  = (k >= 5 && k <= 12) ? 1 : 0;
            e_re = (k < 5) ? 0 : ((k <= 12) ? k - 4 : 8);
            check("d4m0_vld", ov[0], e_v);
            check("d4m0_re", ore[0], e_re);
            check("d4m0_im", oim[0], -e_re);
            j    = k - 1;
            e_v  = (k >= 1 && k <= 12) ? 1 : 0;
            e_re = (k < 1) ? 0 : ((k <= 12) ? ((j >= 4) ? j - 3 : 0) : 8);
            check("d4m1_vld", ov[1], e_v);
            check("d4m1_re", ore[1], e_re);
            check("d4m1_im", oim[1], -e_re);
        end

        // DEPTH=3 with gapped input: one accept every third cycle
        do_reset();
        for (int k = 0; k < 25; k++) begin
            n = k / 3;
            drive((k % 3 == 0) && (k <= 21), n + 1);
            step();
            m    = (k - 1) / 3;
            e_v  = ((k % 3 == 1) && (m >= 3)) ? 1 : 0;
            e_re = (m >= 3) ? m - 2 : 0;
            check("d3_vld", ov[2], e_v);
            check("d3_re", ore[2], e_re);
            check("d3_im", oim[2], -e_re);
        end

        // DEPTH=5: clear coincident with a sixth sample, then refill
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, k + 1);
            step();
            check("d5_fill_vld", ov[3], 0);
        end
        drive(1'b1, 99);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("d5_clr_vld", ov[3], 0);
        check("d5_clr_re", ore[3], 0);
        check("d5_clr_im", oim[3], 0);
        for (int k = 6; k < 17; k++) begin
            drive(1'b1, 101 + (k - 6));
            step();
            e_v  = (k >= 12) ? 1 : 0;
            e_re = (k >= 12) ? 101 + (k - 12) : 0;
            check("d5_refill_vld", ov[3], e_v);
            check("d5_refill_re", ore[3], e_re);
        end

        // Asynchronous reset mid-stream on DEPTH=4
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k + 1);
            step();
        end
        check("pre_arst_vld", ov[0], 1);
        check("pre_arst_re", ore[0], 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_vld", ov[0], 0);
        check("arst_re", ore[0], 0);
        check("arst_im", oim[0], 0);
        drive(1'b0, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 50 + k);
            step();
            e_v  = (k >= 5) ? 1 : 0;
            e_re = (k >= 5) ? 50 + (k - 5) : 0;
            check("post_arst_vld", ov[0], e_v);
            check("post_arst_re", ore[0], e_re);
            j    = k - 1;
            e_re = (k >= 1 && j >= 4) ? 50 + (j - 4) : 0;
            check("post_arst_m1_vld", ov[1], (k >= 1) ? 1 : 0);
            check("post_arst_m1_re", ore[1], e_re);
        end

        // DEPTH=1 and DEPTH=4096 with extreme values over three full wraps
        do_reset();
        nlong = 3 * 4096 + 8;
        for (int k = 0; k < nlong + 2; k++) begin
            in_valid = (k < nlong);
            in_re    = sre(k);
            in_im    = ~sre(k);
            step();
            e_v = (k >= 2 && k <= nlong) ? 1 : 0;
            check("d1_vld", ov[4], e_v);
            if (e_v == 1) begin
                check("d1_re", ore[4], sre(k - 2));
                check("d1_im", oim[4], ~sre(k - 2));
            end else if (k < 2) begin
                check("d1_re_pre", ore[4], 0);
            end
            e_v = (k >= 4097 && k <= nlong) ? 1 : 0;
            check("d4096_vld", ov[5], e_v);
            if (e_v == 1) begin
                check("d4096_re", ore[5], sre(k - 4097));
                check("d4096_im", oim[5], ~sre(k - 4097));
            end else if (k < 4097) begin
                check("d4096_re_pre", ore[5], 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
